// File: rtl/fetch_defs.sv
// Shared definitions for the fetch-stage controller: state and redirect-source
// encodings, boot/exception addresses and the redirect priority helper.
package fetch_defs;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_J    = 2'd2,
    SRC_JR   = 2'd3
  } redir_src_e;

  localparam logic [31:0] INIT_PC_DEFAULT    = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

  // Simultaneous redirects are legal; the register jump wins, then j, then branch.
  function automatic redir_src_e redir_select(input logic jr, input logic j, input logic br);
    if (jr)      return SRC_JR;
    else if (j)  return SRC_J;
    else if (br) return SRC_BR;
    else         return SRC_NONE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      r_cnt <= '0;
    else if (inc && !(&r_cnt))
      r_cnt <= r_cnt + 1'b1;
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: next-PC selection, redirect buffering across stalls,
// fetch halt and stall-cycle counting.
module fetch_sequencer
  import fetch_defs::*;
#(
  parameter logic [31:0] INIT_PC    = INIT_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             j_valid,
  input  logic [31:0]      j_target,
  input  logic             jr_valid,
  input  logic [31:0]      jr_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [31:0]      epc,
  input  logic             halt_req,
  output logic [31:0]      npc,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             adel,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  fetch_state_e r_state, w_next_state;
  logic [31:0]  r_pend_target, w_pend_next;
  logic         r_halted;

  redir_src_e   w_src;
  logic [31:0]  w_redir_target, w_sel, w_npc;
  logic         w_pc_en, w_ifid_en, w_flush, w_adel, w_stall_inc;

  assign w_src = redir_select(jr_valid, j_valid, br_taken);

  always_comb begin
    case (w_src)
      SRC_JR:  w_redir_target = jr_target;
      SRC_J:   w_redir_target = j_target;
      SRC_BR:  w_redir_target = br_target;
      default: w_redir_target = pc + 32'd4;
    endcase
  end

  // NOTE: every signal gets a default up front so no path through the priority chain infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_pend_next  = r_pend_target;
    w_sel        = pc + 32'd4;
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_flush      = 1'b0;
    if (r_state == ST_HALT) begin
      w_sel     = pc;
      w_pc_en   = 1'b0;
      w_ifid_en = 1'b0;
      w_flush   = 1'b1;
    end else if (exc_req || eret) begin
      w_sel        = exc_req ? EXC_VECTOR : epc;
      w_flush      = 1'b1;
      w_next_state = ST_RUN;
      w_pend_next  = '0;
    end else if (stall) begin
      w_sel     = pc;
      w_pc_en   = 1'b0;
      w_ifid_en = 1'b0;
      // Only the first redirect seen during a stall is kept.
      if (r_state == ST_RUN && w_src != SRC_NONE) begin
        w_next_state = ST_HOLD;
        w_pend_next  = w_redir_target;
      end
    end else if (r_state == ST_HOLD) begin
      w_sel        = r_pend_target;
      w_next_state = ST_RUN;
    end else if (w_src != SRC_NONE) begin
      w_sel = w_redir_target;
    end
    if (halt_req)
      w_next_state = ST_HALT;
  end

  // Misaligned targets are only meaningful when the PC is actually written.
  assign w_adel      = w_pc_en && (w_sel[1:0] != 2'b00);
  assign w_npc       = w_adel ? EXC_VECTOR : w_sel;
  assign w_stall_inc = (r_state != ST_HALT) && stall && !exc_req && !eret;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_RUN;
      r_pend_target <= '0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_pend_target <= w_pend_next;
      r_halted      <= (w_next_state == ST_HALT);
    end
  end

  // While reset is low the PC register is held at the boot address and IF/ID is flushed.
  assign npc        = reset ? w_npc : INIT_PC;
  assign pc_en      = reset & w_pc_en;
  assign ifid_en    = reset & w_ifid_en;
  assign ifid_flush = ~reset | w_flush | w_adel;
  assign adel       = reset & w_adel;
  assign halted     = r_halted;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (w_stall_inc),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// traffic compared each cycle against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

  localparam logic [31:0] INIT_PC    = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam int          CNT_W      = 4;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      pc, br_target, j_target, jr_target, epc;
  logic             stall, br_taken, j_valid, jr_valid, exc_req, eret, halt_req;
  logic [31:0]      npc;
  logic             pc_en, ifid_en, ifid_flush, adel, halted;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: a halt flag, an optional buffered redirect, and the stall count.
  bit          m_halted;
  bit          m_has_pend;
  logic [31:0] m_pend;
  int          m_cnt;

  fetch_sequencer #(
    .INIT_PC    (INIT_PC),
    .EXC_VECTOR (EXC_VECTOR),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .j_valid    (j_valid),
    .j_target   (j_target),
    .jr_valid   (jr_valid),
    .jr_target  (jr_target),
    .exc_req    (exc_req),
    .eret       (eret),
    .epc        (epc),
    .halt_req   (halt_req),
    .npc        (npc),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .ifid_flush (ifid_flush),
    .adel       (adel),
    .halted     (halted),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", tag, got, want, $time);
  endtask

  task automatic idle();
    stall = 0; br_taken = 0; j_valid = 0; jr_valid = 0;
    exc_req = 0; eret = 0; halt_req = 0;
  endtask

  // Compare every output with what the fetch rules predict for the current inputs,
  // then advance the model across the next rising edge.
  task automatic step();
    logic [31:0] e_npc, tgt;
    bit e_pc_en, e_ifid_en, e_flush, e_adel, npc_known;
    e_npc = '0; npc_known = 1; e_adel = 0; e_flush = 0;
    e_pc_en = 1; e_ifid_en = 1;
    if (m_halted) begin
      e_pc_en = 0; e_ifid_en = 0; e_flush = 1; npc_known = 0;
    end else if (exc_req) begin
      e_npc = EXC_VECTOR; e_flush = 1;
    end else if (eret) begin
      e_npc = epc; e_flush = 1;
    end else if (stall) begin
      e_pc_en = 0; e_ifid_en = 0; npc_known = 0;
    end else if (m_has_pend) e_npc = m_pend;
    else if (jr_valid)       e_npc = jr_target;
    else if (j_valid)        e_npc = j_target;
    else if (br_taken)       e_npc = br_target;
    else                     e_npc = pc + 32'd4;
    if (e_pc_en && e_npc[1:0] != 2'b00) begin
      e_npc = EXC_VECTOR; e_flush = 1; e_adel = 1;
    end
    #2;
    if (npc_known) check("npc", npc, e_npc);
    check("pc_en", pc_en, e_pc_en);
    check("ifid_en", ifid_en, e_ifid_en);
    check("ifid_flush", ifid_flush, e_flush);
    check("adel", adel, e_adel);
    check("halted", halted, m_halted);
    check("stall_cnt", stall_cnt, m_cnt);
    @(posedge clk);
    if (!m_halted) begin
      if (stall && !exc_req && !eret && m_cnt < CNT_MAX) m_cnt++;
      if (exc_req || eret) m_has_pend = 0;
      else if (stall) begin
        if (!m_has_pend && (jr_valid || j_valid || br_taken)) begin
          tgt = jr_valid ? jr_target : (j_valid ? j_target : br_target);
          m_has_pend = 1; m_pend = tgt;
        end
      end else m_has_pend = 0;
    end
    if (halt_req) m_halted = 1;
    #1;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must respond immediately.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    m_halted = 0; m_has_pend = 0; m_cnt = 0;
    check("rst_npc", npc, INIT_PC);
    check("rst_pc_en", pc_en, 1'b0);
    check("rst_ifid_en", ifid_en, 1'b0);
    check("rst_flush", ifid_flush, 1'b1);
    check("rst_adel", adel, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_cnt", stall_cnt, 0);
    #2;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    reset = 1'b0;
    pc = INIT_PC; br_target = '0; j_target = '0; jr_target = '0; epc = '0;
    idle();
    m_halted = 0; m_has_pend = 0; m_pend = '0; m_cnt = 0;
    #3;
    do_reset();

    // Boot: sequential fetch from the reset address.
    step();
    check("boot_npc", npc, 32'h0000_3004);

    // Branch alone, then branch and jr together.
    pc = 32'h0000_3008; br_taken = 1; br_target = 32'h0000_3100;
    #2; check("br_npc", npc, 32'h0000_3100); check("br_noflush", ifid_flush, 1'b0);
    step();
    jr_valid = 1; jr_target = 32'h0000_3200;
    #2; check("jr_over_br", npc, 32'h0000_3200);
    step();

    // Three-cycle stall: j in cycle 1 is buffered, br in cycle 2 ignored.
    idle(); stall = 1; j_valid = 1; j_target = 32'h0000_3400; step();
    idle(); stall = 1; br_taken = 1; br_target = 32'h0000_3500; step();
    idle(); stall = 1; step();
    check("stall3_cnt", stall_cnt, 3);
    idle(); pc = 32'h0000_300C;
    #2; check("hold_npc", npc, 32'h0000_3400); check("hold_pc_en", pc_en, 1'b1);
    step();
    step();

    // Exception while a redirect is buffered: vector taken, pending dropped.
    idle(); stall = 1; jr_valid = 1; jr_target = 32'h0000_3600; step();
    stall = 1; jr_valid = 0; exc_req = 1;
    #2; check("exc_npc", npc, EXC_VECTOR); check("exc_cnt_hold", stall_cnt, 4);
    step();
    idle(); pc = 32'h0000_4180;
    #2; check("exc_dropped_pend", npc, 32'h0000_4184);
    step();
    eret = 1; epc = 32'h0000_3010;
    #2; check("eret_npc", npc, 32'h0000_3010); check("eret_flush", ifid_flush, 1'b1);
    step();

    // Misaligned jr target raises a one-cycle address error.
    idle(); pc = 32'h0000_3014; jr_valid = 1; jr_target = 32'h0000_3102;
    #2; check("adel_pulse", adel, 1'b1);
    step();
    idle(); step();

    // Halt, ignore a later exception, then leave via reset mid-halt.
    halt_req = 1; step();
    idle(); step();
    exc_req = 1; step();
    exc_req = 0; step();
    do_reset();
    step();

    // Saturation: 20 stall cycles on a 4-bit counter.
    idle(); stall = 1;
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt", stall_cnt, CNT_MAX);
    idle(); step();

    // Randomized traffic with occasional halts and resets.
    for (int i = 0; i < 800; i++) begin
      if (($urandom_range(0, 149) == 0) || (m_halted && $urandom_range(0, 5) == 0)) begin
        idle();
        #1;
        do_reset();
      end
      pc        = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : rand_addr();
      br_target = rand_addr();
      j_target  = rand_addr();
      jr_target = rand_addr();
      epc       = rand_addr();
      stall     = ($urandom_range(0, 9) < 4);
      br_taken  = ($urandom_range(0, 3) == 0);
      j_valid   = ($urandom_range(0, 4) == 0);
      jr_valid  = ($urandom_range(0, 5) == 0);
      exc_req   = ($urandom_range(0, 19) == 0);
      eret      = ($urandom_range(0, 19) == 0);
      halt_req  = ($urandom_range(0, 79) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
